// File: rtl/cirno9_sram_ctrl.sv
// cirno9_sram_ctrl: single-request SRAM controller for the cirno9 load/store bus.
// Words are interleaved across BANKS banks (bank = word mod BANKS, row = word / BANKS).
// Each accepted request waits WAIT cycles, then the array access and the response
// happen together. Misaligned or out-of-range requests are answered with o_err and
// leave memory untouched.
module cirno9_sram_ctrl #(
    parameter int              AW         = 32,
    parameter int              DW         = 32,
    parameter int              BANKS      = 2,
    parameter int              BANK_WORDS = 1024,
    parameter int              WAIT       = 1,
    parameter logic [AW-1:0]   BASE       = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ren,
    input  logic [DW/8-1:0]   i_wen,
    input  logic [AW-1:0]     i_adr,
    input  logic [DW-1:0]     i_wdat,
    output logic              o_rdy,
    output logic [DW-1:0]     o_rdat,
    output logic              o_done,
    output logic              o_err
);

    localparam int BW         = DW / 8;
    localparam int LANE_SHIFT = $clog2(BW);
    localparam int BANK_SHIFT = $clog2(BANKS);
    localparam int BANK_BITS  = (BANKS > 1) ? BANK_SHIFT : 1;
    localparam int ROW_BITS   = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;
    localparam logic [AW-1:0] TOTAL_WORDS = AW'(BANKS * BANK_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // ---------------------------------------------------------------
    // Request decode (combinational, on the live bus)
    // ---------------------------------------------------------------
    logic [AW-1:0]        w_off;
    logic [AW-1:0]        w_word;
    logic                 w_misal;
    logic                 w_below;
    logic                 w_range;
    logic                 w_dec_err;
    logic [BANK_BITS-1:0] w_dec_bank;
    logic [ROW_BITS-1:0]  w_dec_row;
    logic                 w_req;
    logic                 w_acc;

    assign w_off   = i_adr - BASE;
    assign w_word  = w_off >> LANE_SHIFT;
    assign w_below = (i_adr < BASE);
    assign w_range = (w_word >= TOTAL_WORDS);

    generate
        if (LANE_SHIFT > 0) begin : g_misal
            assign w_misal = |w_off[LANE_SHIFT-1:0];
        end else begin : g_nomisal
            assign w_misal = 1'b0;
        end
        if (BANKS > 1) begin : g_bsel
            assign w_dec_bank = w_word[BANK_BITS-1:0];
        end else begin : g_nobsel
            assign w_dec_bank = '0;
        end
    endgenerate

    assign w_dec_row = w_word[BANK_SHIFT +: ROW_BITS];
    assign w_dec_err = w_misal | w_below | w_range;

    // ---------------------------------------------------------------
    // Control state
    // ---------------------------------------------------------------
    state_t               r_state;
    logic [3:0]           r_cnt;
    logic                 r_rdy;
    logic                 r_done;
    logic                 r_err_o;

    // Captured request (only meaningful while waiting)
    logic                 r_ren;
    logic [BW-1:0]        r_wen;
    logic [DW-1:0]        r_wdat;
    logic [BANK_BITS-1:0] r_bank;
    logic [ROW_BITS-1:0]  r_row;
    logic                 r_err;

    // A request is taken on any edge where it is present and we advertised ready;
    // reset on the same edge wins.
    assign w_req = i_ren | (|i_wen);
    assign w_acc = w_req & r_rdy & ~rst;

    // ---------------------------------------------------------------
    // Commit port: the edge that enters RESP performs the array access.
    // With no wait states that edge is the acceptance edge itself, so the
    // live decode drives the arrays; otherwise the captured request does.
    // ---------------------------------------------------------------
    logic                 w_commit;
    logic                 w_c_ren;
    logic [BW-1:0]        w_c_wen;
    logic [DW-1:0]        w_c_wdat;
    logic [BANK_BITS-1:0] w_c_bank;
    logic [ROW_BITS-1:0]  w_c_row;
    logic                 w_c_err;
    logic                 w_c_ok;

    generate
        if (WAIT == 0) begin : g_direct
            assign w_commit = w_acc;
            assign w_c_ren  = i_ren;
            assign w_c_wen  = i_wen;
            assign w_c_wdat = i_wdat;
            assign w_c_bank = w_dec_bank;
            assign w_c_row  = w_dec_row;
            assign w_c_err  = w_dec_err;
        end else begin : g_captured
            assign w_commit = (r_state == S_WAIT) && (r_cnt == 4'd0) && !rst;
            assign w_c_ren  = r_ren;
            assign w_c_wen  = r_wen;
            assign w_c_wdat = r_wdat;
            assign w_c_bank = r_bank;
            assign w_c_row  = r_row;
            assign w_c_err  = r_err;
        end
    endgenerate

    assign w_c_ok = w_commit & ~w_c_err;

    // Sequencer: IDLE/RESP accept, WAIT counts down, outputs registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rdy   <= 1'b1;
            r_done  <= 1'b0;
            r_err_o <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_RESP: begin
                    if (w_acc) begin
                        if (WAIT > 0) begin
                            r_state <= S_WAIT;
                            r_cnt   <= 4'(WAIT - 1);
                            r_rdy   <= 1'b0;
                            r_done  <= 1'b0;
                            r_err_o <= 1'b0;
                        end else begin
                            r_state <= S_RESP;
                            r_rdy   <= 1'b1;
                            r_done  <= 1'b1;
                            r_err_o <= w_dec_err;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        r_rdy   <= 1'b1;
                        r_done  <= 1'b0;
                        r_err_o <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                        r_rdy   <= 1'b1;
                        r_done  <= 1'b1;
                        r_err_o <= r_err;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_rdy   <= 1'b1;
                    r_done  <= 1'b0;
                    r_err_o <= 1'b0;
                end
            endcase
        end
    end

    // Capture the request on acceptance; reset simply leaves it stale.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_ren  <= i_ren;
            r_wen  <= i_wen;
            r_wdat <= i_wdat;
            r_bank <= w_dec_bank;
            r_row  <= w_dec_row;
            r_err  <= w_dec_err;
        end
    end

    // ---------------------------------------------------------------
    // Read-data steering: o_rdat holds the last read response; an error
    // response forces it to zero until the next good read.
    // ---------------------------------------------------------------
    logic                 r_rzero;
    logic [BANK_BITS-1:0] r_rsel;
    logic [DW-1:0]        w_bank_rd [BANKS];

    // Track which bank's read register holds the current response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rzero <= 1'b1;
            r_rsel  <= '0;
        end else if (w_commit) begin
            if (w_c_err) begin
                r_rzero <= 1'b1;
            end else if (w_c_ren) begin
                r_rzero <= 1'b0;
                r_rsel  <= w_c_bank;
            end
        end
    end

    // ---------------------------------------------------------------
    // Banks: one inferred RAM per bank, registered read-first port with
    // byte-lane write enables. Contents survive reset.
    // ---------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < BANKS; gi++) begin : g_bank
            logic [DW-1:0] r_mem [BANK_WORDS];
            logic [DW-1:0] r_rd;

            // Read the old word and merge enabled byte lanes on commit.
            always_ff @(posedge clk) begin
                if (w_c_ok && (w_c_bank == BANK_BITS'(gi))) begin
                    if (w_c_ren) begin
                        r_rd <= r_mem[w_c_row];
                    end
                    for (int li = 0; li < BW; li++) begin
                        if (w_c_wen[li]) begin
                            r_mem[w_c_row][li*8 +: 8] <= w_c_wdat[li*8 +: 8];
                        end
                    end
                end
            end

            assign w_bank_rd[gi] = r_rd;
        end
    endgenerate

    assign o_rdy  = r_rdy;
    assign o_done = r_done;
    assign o_err  = r_err_o;
    assign o_rdat = r_rzero ? '0 : w_bank_rd[r_rsel];

endmodule

// File: tb/tb_cirno9_sram_ctrl.sv
// Testbench for cirno9_sram_ctrl: three instances (WAIT = 0, 1, 3) with the default
// 2 x 1024-word geometry at BASE 0, checked against a word-array reference model.
module tb_cirno9_sram_ctrl;

    localparam int WAITS [3] = '{0, 1, 3};

    logic        clk;
    logic        rst  [3];
    logic        ren  [3];
    logic [3:0]  wen  [3];
    logic [31:0] adr  [3];
    logic [31:0] wdat [3];
    logic        rdy  [3];
    logic [31:0] rdat [3];
    logic        done [3];
    logic        err  [3];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: word-addressed memory plus the held read-data value.
    logic [31:0] ref_mem  [3][2048];
    logic [31:0] ref_rdat [3];

    cirno9_sram_ctrl #(.WAIT(0)) dut0 (
        .clk(clk), .rst(rst[0]), .i_ren(ren[0]), .i_wen(wen[0]), .i_adr(adr[0]),
        .i_wdat(wdat[0]), .o_rdy(rdy[0]), .o_rdat(rdat[0]), .o_done(done[0]), .o_err(err[0]));
    cirno9_sram_ctrl #(.WAIT(1)) dut1 (
        .clk(clk), .rst(rst[1]), .i_ren(ren[1]), .i_wen(wen[1]), .i_adr(adr[1]),
        .i_wdat(wdat[1]), .o_rdy(rdy[1]), .o_rdat(rdat[1]), .o_done(done[1]), .o_err(err[1]));
    cirno9_sram_ctrl #(.WAIT(3)) dut2 (
        .clk(clk), .rst(rst[2]), .i_ren(ren[2]), .i_wen(wen[2]), .i_adr(adr[2]),
        .i_wdat(wdat[2]), .o_rdy(rdy[2]), .o_rdat(rdat[2]), .o_done(done[2]), .o_err(err[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one request to the model: 2 banks x 1024 words x 4 bytes = 0x2000 bytes at 0.
    task automatic model_step(input int d, input logic ren_i, input logic [3:0] wen_i,
                              input logic [31:0] adr_i, input logic [31:0] wdat_i,
                              output logic [31:0] e_rdat, output logic e_err);
        int unsigned w;
        logic [31:0] old;
        e_err = (adr_i % 4 != 0) || (adr_i >= 32'h2000);
        if (e_err) begin
            ref_rdat[d] = 32'h0;
        end else begin
            w   = adr_i / 4;
            old = ref_mem[d][w];
            for (int b = 0; b < 4; b++)
                if (wen_i[b]) ref_mem[d][w][8*b +: 8] = wdat_i[8*b +: 8];
            if (ren_i) ref_rdat[d] = old;
        end
        e_rdat = ref_rdat[d];
    endtask

    // One complete transaction: present, wait for acceptance, measure latency, check response.
    task automatic xact(input int d, input logic ren_i, input logic [3:0] wen_i,
                        input logic [31:0] adr_i, input logic [31:0] wdat_i, input string tag);
        logic [31:0] e_rdat;
        logic        e_err;
        int          guard;
        int          lat;
        model_step(d, ren_i, wen_i, adr_i, wdat_i, e_rdat, e_err);
        ren[d] = ren_i; wen[d] = wen_i; adr[d] = adr_i; wdat[d] = wdat_i;
        guard = 0;
        while (!rdy[d] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_accept"}, 32'(guard < 20), 32'd1);
        @(posedge clk); #1;
        ren[d] = 1'b0; wen[d] = 4'h0;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
            if (i == 1 && WAITS[d] > 0) check({tag, "_rdy_low"}, 32'(rdy[d]), 32'd0);
            if (done[d]) lat = i;
        end
        check({tag, "_lat"}, 32'(lat), 32'(WAITS[d] + 1));
        check({tag, "_err"}, 32'(err[d]), 32'(e_err));
        check({tag, "_rdat"}, rdat[d], e_rdat);
        $display("xact %s d=%0d ren=%0b wen=%h adr=%h wdat=%h rdat=%h err=%0b lat=%0d",
                 tag, d, ren_i, wen_i, adr_i, wdat_i, rdat[d], err[d], lat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] e_rdat;
        logic        e_err;
        logic [31:0] r_adr;
        logic        r_ren;
        logic [3:0]  r_wen;
        int          d;
        int          k;

        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; ren[i] = 1'b0; wen[i] = 4'h0; adr[i] = 32'h0; wdat[i] = 32'h0;
            ref_rdat[i] = 32'h0;
        end

        // Reset for two cycles, then check idle outputs on every instance.
        @(posedge clk); @(posedge clk); #1;
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_rdy",  32'(rdy[i]),  32'd1);
            check("reset_done", 32'(done[i]), 32'd0);
            check("reset_err",  32'(err[i]),  32'd0);
            check("reset_rdat", rdat[i],      32'd0);
        end

        // Fill the low 64 words of each instance with known data.
        for (int i = 0; i < 3; i++)
            for (int w = 0; w < 64; w++)
                xact(i, 1'b0, 4'hF, 32'(w * 4), $urandom, "init");

        // Directed sequence on WAIT=1.
        xact(1, 1'b0, 4'hF, 32'h8, 32'hDEADBEEF, "wr8");
        check("bank0_row1", dut1.g_bank[0].r_mem[1], 32'hDEADBEEF);
        xact(1, 1'b1, 4'h0, 32'h8, 32'h0, "rd8");
        xact(1, 1'b1, 4'b0010, 32'h8, 32'h0000AA00, "rdfirst8");
        xact(1, 1'b1, 4'h0, 32'h8, 32'h0, "rd8_merged");
        xact(1, 1'b1, 4'h0, 32'h6, 32'h0, "misal");
        xact(1, 1'b0, 4'hF, 32'h2000, 32'hCAFEF00D, "oor_wr");
        xact(1, 1'b1, 4'h0, 32'h0, 32'h0, "rd0_after_oor");
        xact(1, 1'b0, 4'hF, 32'h1FFC, $urandom, "wr_last");
        xact(1, 1'b1, 4'h0, 32'h1FFC, 32'h0, "rd_last");

        // Back-to-back reads on WAIT=0: ready stays high, done on four consecutive cycles.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            ren[0] = 1'b1; wen[0] = 4'h0; adr[0] = 32'(i * 4); wdat[0] = 32'h0;
            check("b2b_rdy", 32'(rdy[0]), 32'd1);
            model_step(0, 1'b1, 4'h0, 32'(i * 4), 32'h0, e_rdat, e_err);
            @(posedge clk); #1;
            if (i == 3) ren[0] = 1'b0;
            @(negedge clk);
            check("b2b_done", 32'(done[0]), 32'd1);
            check("b2b_err",  32'(err[0]),  32'(e_err));
            check("b2b_rdat", rdat[0], e_rdat);
            $display("xact b2b d=0 adr=%h rdat=%h", 32'(i * 4), rdat[0]);
        end
        @(negedge clk);
        check("b2b_done_end", 32'(done[0]), 32'd0);

        // Randomised traffic across all instances.
        for (int n = 0; n < 150; n++) begin
            d = $urandom_range(0, 2);
            k = $urandom_range(0, 9);
            r_ren = 1'($urandom_range(0, 1));
            r_wen = 4'($urandom_range(0, 15));
            if (!r_ren && r_wen == 4'h0) r_ren = 1'b1;
            if (k == 0)      r_adr = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
            else if (k == 1) r_adr = 32'h2000 + 32'($urandom_range(0, 1023) * 4);
            else             r_adr = 32'($urandom_range(0, 63) * 4);
            xact(d, r_ren, r_wen, r_adr, $urandom, "rand");
        end

        // Reset during the second wait cycle of a WAIT=3 write drops it.
        ren[2] = 1'b0; wen[2] = 4'hF; adr[2] = 32'h10; wdat[2] = 32'h12345678;
        check("rmo_rdy", 32'(rdy[2]), 32'd1);
        @(posedge clk); #1;
        wen[2] = 4'h0;
        @(posedge clk); #1;
        check("rmo_busy", 32'(rdy[2]), 32'd0);
        rst[2] = 1'b1;
        @(posedge clk); #1;
        rst[2] = 1'b0;
        ref_rdat[2] = 32'h0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rmo_no_done", 32'(done[2]), 32'd0);
            check("rmo_idle_rdy", 32'(rdy[2]), 32'd1);
        end
        check("rmo_rdat", rdat[2], 32'h0);
        check("rmo_err",  32'(err[2]), 32'd0);
        xact(2, 1'b1, 4'h0, 32'h10, 32'h0, "rmo_readback");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
